seq_div: RTL

Multi-cycle 32-bit integer divider for the DCPU execute stage (DIV/DIVU). It is the inverse-direction companion of the carry-lookahead adder/subtractor, performing division by repeated trial subtraction. It uses a start/busy/done handshake so the pipeline can stall while it runs, and holds its results until the next operation.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 31 +++
 rtl/seq_div.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
// Holds the FSM state encoding and the default width/iteration constants.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem      - current partial remainder (always < dvs between steps)
//   quo      - current quotient/dividend shift register
//   dvs      - divisor magnitude
//   next_rem - partial remainder after this step
//   next_quo - quotient register after this step (new bit enters at LSB)
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The shifted remainder can exceed WIDTH bits, so the trial subtract is
    // WIDTH+1 wide. Because rem < dvs, a non-negative difference always fits
    // in WIDTH bits and its top bit doubles as the borrow flag.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs};
    assign next_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign next_quo = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed/unsigned integer divider (restoring, one bit per cycle).
// Handshake: start is sampled on a rising edge only while busy=0; that edge
// latches sign/dividend/divisor and raises busy. busy stays high for ITER+1
// cycles, then done pulses for exactly one cycle with q/r/div_by_zero valid.
// Results hold until the next accepted start; start in the done cycle is
// accepted. start while busy=1 is ignored.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start        - operation request
//   sign         - 1 = signed (truncating toward zero), 0 = unsigned
//   dividend     - dividend, sampled with start
//   divisor      - divisor, sampled with start
//   q, r         - registered quotient and remainder
//   busy         - operation in progress
//   done         - one-cycle result-valid pulse
//   div_by_zero  - latched divisor was zero (q = all ones, r = dividend)
module seq_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(ITER) + 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dend_raw;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic [WIDTH-1:0] dend_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    assign dend_mag_in = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_mag_in  = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dvs      (dvs_mag),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs_mag     <= '0;
            dend_raw    <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            q           <= '0;
            r           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        quo      <= dend_mag_in;
                        rem      <= '0;
                        dvs_mag  <= dvs_mag_in;
                        dend_raw <= dividend;
                        neg_q    <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r    <= sign & dividend[WIDTH-1];
                        dz       <= (divisor == '0);
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Divide-by-zero bypasses sign correction entirely.
                    if (dz) begin
                        q <= '1;
                        r <= dend_raw;
                    end else begin
                        q <= neg_q ? -quo : quo;
                        r <= neg_r ? -rem : rem;
                    end
                    div_by_zero <= dz;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
